// File: rtl/md_ctrl.sv
// Multiply/divide sequencer owning HI/LO: results are computed at the start edge and committed after
// MULT_CYCLES/DIV_CYCLES busy cycles; starts while busy are dropped, and md_stall holds D-stage MD ops.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_is_md,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        md_stall
);

  typedef enum logic { S_IDLE = 1'b0, S_RUN = 1'b1 } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] shi_q, shi_d, slo_q, slo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               a_neg, b_neg;
  logic        [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes so the -2^31 / -1 case simply wraps.
  assign a_neg = (md_op == OP_DIV) & A[31];
  assign b_neg = (md_op == OP_DIV) & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      shi_q   <= 32'd0;
      slo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {shi_d, slo_d} = prod_s;
              cnt_d          = 8'(MULT_CYCLES);
              state_d        = S_RUN;
            end
            OP_MULTU: begin
              {shi_d, slo_d} = prod_u;
              cnt_d          = 8'(MULT_CYCLES);
              state_d        = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide-by-zero still burns the full latency but leaves HI/LO intact.
              shi_d   = (B == 32'd0) ? hi_q : rem;
              slo_d   = (B == 32'd0) ? lo_q : quot;
              cnt_d   = 8'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          hi_d    = shi_q;
          lo_d    = slo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_RUN);
    HI       = hi_q;
    LO       = lo_q;
    md_stall = D_is_md & (start | busy);
  end

endmodule
